// File: rtl/divmul_pkg.sv
// Shared definitions for the Booth multiplier and its companion divider:
// FSM state encoding and default operand width.
package divmul_pkg;
  localparam int DEFAULT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDSUB,
    SHIFT,
    ACC,
    DONE
  } state_t;
endpackage

// File: rtl/booth_addsub.sv
// Combinational (n+1)-bit Booth step: subtract, add or pass M depending on
// the recoded pair {Q[0], q_-1}.
module booth_addsub
  import divmul_pkg::*;
#(
  parameter int n = DEFAULT_W
) (
  input  logic [n:0] acc,
  input  logic [n:0] mcand,
  input  logic [1:0] pair,
  output logic [n:0] sum
);

  logic signed [n:0] acc_s;
  logic signed [n:0] mcand_s;

  assign acc_s   = acc;
  assign mcand_s = mcand;

  always_comb begin
    sum = acc_s;
    case (pair)
      2'b10:   sum = acc_s - mcand_s;
      2'b01:   sum = acc_s + mcand_s;
      default: sum = acc_s;
    endcase
  end

endmodule

// File: rtl/booth_mul.sv
// Radix-2 Booth signed multiplier, fixed 2n+2 cycle latency.
// Define BOOTH_MUL_ADDEND_EN to add the addend port and accumulate R in ACC.
module booth_mul
  import divmul_pkg::*;
#(
  parameter int n = DEFAULT_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [n-1:0]   multiplicand,
  input  logic [n-1:0]   multiplier,
`ifdef BOOTH_MUL_ADDEND_EN
  input  logic [n-1:0]   addend,
`endif
  output logic [2*n-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CNT_W = $clog2(n + 1);

  state_t                state;
  logic signed [n:0]     a_reg;
  logic signed [n-1:0]   m_reg;
  logic signed [n-1:0]   q_reg;
  logic                  q_m1;
  logic [CNT_W-1:0]      cnt;
  logic [n:0]            step_sum;
  logic signed [2*n-1:0] acc_sum;

  booth_addsub #(.n(n)) u_addsub (
    .acc   (a_reg),
    .mcand ({m_reg[n-1], m_reg}),
    .pair  ({q_reg[0], q_m1}),
    .sum   (step_sum)
  );

`ifdef BOOTH_MUL_ADDEND_EN
  logic signed [n-1:0] r_reg;

  // A's top bit is only a guard bit; the true product lives in {A[n-1:0],Q}.
  assign acc_sum = $signed({a_reg[n-1:0], q_reg}) + (2*n)'(r_reg);
`else
  assign acc_sum = $signed({a_reg[n-1:0], q_reg});
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      a_reg   <= '0;
      m_reg   <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef BOOTH_MUL_ADDEND_EN
      r_reg   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
`ifdef BOOTH_MUL_ADDEND_EN
            r_reg <= addend;
`endif
            a_reg <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADDSUB;
          end
        end
        ADDSUB: begin
          a_reg <= step_sum;
          state <= SHIFT;
        end
        SHIFT: begin
          a_reg <= {a_reg[n], a_reg[n:1]};
          q_reg <= {a_reg[0], q_reg[n-1:1]};
          q_m1  <= q_reg[0];
          cnt   <= cnt + 1'b1;
          state <= (cnt == CNT_W'(n - 1)) ? ACC : ADDSUB;
        end
        ACC: begin
          product <= acc_sum;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul.sv
// Directed bench for booth_mul (n=4); expectations follow BOOTH_MUL_ADDEND_EN.
module tb_booth_mul;

  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [N-1:0]   addend;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  int n_checks;
  int n_fail;

  booth_mul #(.n(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef BOOTH_MUL_ADDEND_EN
    .addend       (addend),
`endif
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Cycle k is the interval following the (k-1)-th edge after the start edge.
  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [3:0] r,
                        input logic [7:0] exp, input bit repulse, input string tag);
    int done_cyc;
    int done_cnt;
    logic [7:0] prev;
    done_cyc = -1;
    done_cnt = 0;
    @(negedge clk);
    prev         = product;
    multiplicand = m;
    multiplier   = q;
    addend       = r;
    start        = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 9)  check({tag, "_hold"}, {24'd0, product}, {24'd0, prev});
      if (cyc == 10) check({tag, "_busy10"}, {31'd0, busy}, 32'd1);
      if (cyc == 11) check({tag, "_busy11"}, {31'd0, busy}, 32'd0);
      start        = repulse && (cyc == 3 || cyc == 6);
      multiplicand = ~m;
      multiplier   = q + 4'd5;
      addend       = ~r;
    end
    check({tag, "_done_cyc"}, done_cyc, 10);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_product"}, {24'd0, product}, {24'd0, exp});
  endtask

  task automatic reset_mid_op();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    multiplicand = 4'd2;
    multiplier   = 4'd3;
    addend       = 4'd1;
    start        = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_product", {24'd0, product}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rst_mid_no_done", done_cnt, 0);
  endtask

  initial begin
    int a, b, qt, rm;
    logic [7:0] exp;
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    addend       = '0;
    #12;
    check("rst_product", {24'd0, product}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

`ifdef BOOTH_MUL_ADDEND_EN
    run_op(4'd2,  4'd3,  4'd1,  8'h07, 1'b0, "m2_q3_r1");
    run_op(4'h8,  4'h8,  4'd0,  8'h40, 1'b0, "mneg8_qneg8");
    run_op(4'hD,  4'd5,  4'hE,  8'hEF, 1'b0, "mneg3_q5_rneg2");
    run_op(4'd7,  4'h8,  4'd7,  8'hCF, 1'b1, "m7_qneg8_repulse");
    run_op(4'h8,  4'h8,  4'h8,  8'h38, 1'b0, "all_neg8");
    run_op(4'd7,  4'd7,  4'd7,  8'h38, 1'b0, "all_7");
    run_op(4'd0,  4'd5,  4'hF,  8'hFF, 1'b0, "m0_rneg1");
`else
    run_op(4'd2,  4'd3,  4'd1,  8'h06, 1'b0, "m2_q3");
    run_op(4'h8,  4'h8,  4'd0,  8'h40, 1'b0, "mneg8_qneg8");
    run_op(4'hD,  4'd5,  4'hE,  8'hF1, 1'b0, "mneg3_q5");
    run_op(4'd7,  4'h8,  4'd7,  8'hC8, 1'b1, "m7_qneg8_repulse");
    run_op(4'h8,  4'h8,  4'h8,  8'h40, 1'b0, "all_neg8");
    run_op(4'd7,  4'd7,  4'd7,  8'h31, 1'b0, "all_7");
    run_op(4'd0,  4'd5,  4'hF,  8'h00, 1'b0, "m0");
`endif

    reset_mid_op();
    run_op(4'd1, 4'd1, 4'd0, 8'h01, 1'b0, "after_reset");

    // Start held through the DONE cycle is taken on the next IDLE edge.
    run_op(4'd3, 4'd3, 4'd0, 8'h09, 1'b0, "pre_hold");
    @(negedge clk);
    multiplicand = 4'd3;
    multiplier   = 4'd2;
    addend       = 4'd0;
    start        = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) @(negedge clk);
    check("held_start_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) @(negedge clk);
    check("held_start_product", {24'd0, product}, 32'h06);

    for (a = -8; a <= 7; a++) begin
      for (b = -8; b <= 7; b++) begin
        if (b == 0) continue;
        qt = a / b;
        rm = a % b;
        if (qt > 7 || qt < -8) continue;
`ifdef BOOTH_MUL_ADDEND_EN
        exp = 8'(a);
`else
        exp = 8'(b * qt);
`endif
        run_op(4'(b), 4'(qt), 4'(rm), exp, 1'b0, "roundtrip");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul.md
BOOTH_MUL -- requirements
Module: booth_mul

Interface
REQ-001 SHALL have parameter n, default 4: operand width in bits, legal range 2..15.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port multiplicand, input, n bits: two's-complement M, the divisor of the inverse division.
REQ-006 SHALL have port multiplier, input, n bits: two's-complement Q, the quotient of the inverse division.
REQ-007 SHALL have port addend, input, n bits: two's-complement R, the remainder; present only with BOOTH_MUL_ADDEND_EN.
REQ-008 SHALL have port product, output, 2n bits: two's-complement result M*Q(+R).
REQ-009 SHALL have port busy, output, 1 bit: high from the accepted start until the DONE state is left.
REQ-010 SHALL have port done, output, 1 bit: registered one-cycle pulse marking product valid.

Function
REQ-011 SHALL implement a radix-2 Booth signed multiplier with optional remainder accumulation.
REQ-012 SHALL use FSM states IDLE, ADDSUB, SHIFT, ACC and DONE.
REQ-013 SHALL accept start only in IDLE: at the sampling edge it latches M, Q and R, clears A (n+1 bits) and q_-1, and goes to ADDSUB.
REQ-014 In ADDSUB, pair {Q[0],q_-1}=10 SHALL give A-=M, 01 SHALL give A+=M, and 00/11 no change, using (n+1)-bit sign-extended arithmetic; next state is SHIFT.
REQ-015 SHALL arithmetic-right-shift {A,Q,q_-1} by one in SHIFT and increment the iteration counter; after the n-th SHIFT the next state is ACC, otherwise ADDSUB.
REQ-016 ACC SHALL add sign-extended R to the 2n-bit {A[n-1:0],Q}, write the sum to product, and go to DONE.
REQ-017 DONE SHALL drive done=1 for exactly one cycle and then return to IDLE.
REQ-018 Latency SHALL be fixed: done is high in the cycle 2n+2 clocks after the start sampling edge (10 for n=4), independent of operand values.
REQ-019 The result SHALL never overflow 2n signed bits for any legal operands, including M=Q=R=-2^(n-1).
REQ-020 product SHALL hold its last value until the next ACC write and SHALL NOT change during an operation.
REQ-021 start asserted while busy SHALL be ignored with no queuing; start held high in the DONE cycle SHALL be accepted on the following IDLE edge.
REQ-022 Input changes after the start sampling edge SHALL NOT affect the result.

Reset
REQ-023 Reset assertion SHALL immediately force state=IDLE, product=0, busy=0, done=0 and clear counter, A, Q and q_-1, including mid-operation.
REQ-024 After reset deasserts, the first start SHALL behave exactly as from power-up.

Configuration
REQ-025 With BOOTH_MUL_ADDEND_EN defined, the addend port and ACC addition SHALL be present, as described in REQ-016.
REQ-026 Without BOOTH_MUL_ADDEND_EN, the addend port SHALL be absent, ACC SHALL write the plain product M*Q, and latency SHALL remain 2n+2.

Structure
REQ-027 SHALL define the FSM state typedef and the default width constant in shared package divmul_pkg, common with the divider.
REQ-028 SHALL use one sub-module, booth_addsub, a combinational (n+1)-bit add/sub/pass selector driven by {Q[0],q_-1}.

Verification (n=4, macro defined unless noted)
REQ-029 M=2, Q=3, R=1, start -> product=8'h07, done pulse at cycle 10, busy low at cycle 11.
REQ-030 M=-8, Q=-8, R=0 -> product=8'h40; M=-3, Q=5, R=-2 -> product=8'hEF.
REQ-031 M=7, Q=-8, R=7 -> product=8'hCF; start re-pulsed at cycles 3 and 6 -> ignored, single done at cycle 10.
REQ-032 reset low at cycle 5 of an operation -> product=0, busy=0, no done; next start M=1, Q=1, R=0 -> 8'h01.
REQ-033 Divider round-trip: for every dividend/divisor pair, divider quotient/remainder fed in as Q/R with M=divisor -> product equals sign-extended dividend.
REQ-034 Macro undefined: M=2, Q=3 -> product=8'h06, done at cycle 10.
